dmem_ls: RTL and testbench
==========================

# dmem_ls

Clocked, parametrised data memory with an integrated load/store lane unit for the 32-bit processor's MEM stage. It replaces the combinational word-only data memory with:
- byte, halfword and word access with sign or zero extension
- per-byte write enables
- a registered read with a one-cycle request/acknowledge handshake
- alignment and range error reporting
- a hardware zero-initialisation sweep after reset

## Interface
Parameters:
- AWIDTH, 32, byte-address width of Addr
- ALENGTH, 128, depth in 32-bit words; power of two, at least 2
- INIT_ZERO, 1, 1 = clear the array after reset; 0 = skip straight to IDLE

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, synchronous and active-high
- Rdy  out  1  high when a request can be accepted (state IDLE)
- Req  in  1  request strobe, sampled when Rdy=1
- WE2  in  1  1 = store, 0 = load
- Size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as error)
- Uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- Addr  in  AWIDTH  byte address
- WriDat  in  32  store data, right-justified (lane 0 source)
- ReaDat  out  32  load result, valid only while Ack=1
- Ack  out  1  one-cycle pulse, the cycle after an accepted request
- Err  out  1  valid with Ack: misaligned, out-of-range or illegal Size

## Operation
- States:
  - INIT: clears the array.
  - IDLE: accepts requests.
  - On rst, go to INIT if INIT_ZERO=1, otherwise to IDLE.
- INIT:
  - A sweep counter writes 0 to word 0..ALENGTH-1, one word per cycle.
  - After the last word, go to IDLE.
  - Rdy=0 throughout; Req is ignored.
  - rst asserted mid-sweep restarts the sweep at word 0.
- IDLE:
  - Rdy=1. Req=1 accepts a request; the response is presented on the following cycle.
  - Back-to-back requests are allowed every cycle.
- Word index = Addr[IDX+1:2], where IDX = $clog2(ALENGTH).
- Out-of-range: any of Addr[AWIDTH-1:IDX+2] nonzero.
- Misaligned: half with Addr[0]=1, or word with Addr[1:0]≠00.
- Error response:
  - Err=1 and ReaDat=0.
  - The array is not modified.
  - Applies to out-of-range, misaligned and Size=11.
- Store:
  - Byte: WriDat[7:0] is replicated to lane Addr[1:0], with only that byte enable set.
  - Half: WriDat[15:0] is written to lanes {Addr[1],0}+1 and {Addr[1],0}.
  - Word: all four lanes are written.
  - For a store, ReaDat=0 on Ack.
- Load:
  - The addressed lane(s) are right-justified into ReaDat.
  - Uns=0: extend from bit 7 (byte) or bit 15 (half) by sign.
  - Uns=1: extend with zeros.
  - Word loads are unchanged.
- Little-endian: byte lane k = word bits [8k+7:8k].

## Timing
- Reset values: Rdy=0 (1 if INIT_ZERO=0), Ack=0, Err=0, ReaDat=0. The sweep counter is 0.
- Init sweep: Rdy rises exactly ALENGTH cycles after rst deasserts (128 cycles at the default).
- Store:
  - The array is written on the edge that accepts Req.
  - Ack/Err are high for exactly one cycle after that edge.
- Load:
  - Address and control are registered on the accepting edge.
  - The array is read and extended combinationally from the registered values.
  - ReaDat/Ack/Err are valid the next cycle, giving a latency of 1.
- Store at edge N, load of the same word accepted at edge N+1: returns the new data (no bypass needed).
- Load and store to the same word in consecutive cycles keep program order.
- rst in the same cycle as an accepted Req: rst wins. The array is not written and no Ack is produced.
- Ack=0 in every cycle that did not follow an accepted request.

## Structure
- Package dmem_pkg holds:
  - size_t enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state_t enum: INIT, IDLE.
  - Localparam LANES=4.
- Sub-module dmem_lane is the pure-combinational lane logic:
  - Store path: byte-enable and replicated write-data generation from Size/Addr[1:0].
  - Load path: extraction and extension from Size/Addr[1:0]/Uns.
- The top level holds the FSM, sweep counter, request registers, error check and a byte-enabled array inferred as reg [31:0] mem[ALENGTH].

## Test plan
- Reset, INIT_ZERO=1, default depth → Rdy=0 for 128 cycles, then Rdy=1. A word load at 0x1FC returns 0x00000000 with Ack=1, Err=0.
- Word store 0x00006000 at 0x7C, then word load 0x7C next cycle → ReaDat=0x00006000 on the Ack cycle.
- Word store 0x12345678 at 0x10; byte loads at 0x13 with Uns=0 → 0x00000012; half load at 0x10 with Uns=0 → 0x00005678. Byte store 0x80 at 0x11 followed by a byte load at 0x11 with Uns=0 → 0xFFFFFF80; the same load with Uns=1 → 0x00000080. A word load of 0x10 then → 0x12348078.
- Word store at 0x7F → Err=1, ReaDat=0. Half load at 0x81 → Err=1. Word load at 0x200 (out of range) → Err=1. A following word load of 0x7C shows its contents are unchanged.
- rst asserted at sweep cycle 60 → Rdy stays 0 for a further 128 cycles. rst asserted together with Req+WE2 at 0x0 in IDLE → no Ack, and the word stays 0.
- Back-to-back Req every cycle, alternating store/load over 8 addresses → one Ack per request, each one cycle later, all data correct.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data memory: access sizes, FSM states and
// the registered response carried from the accepting edge to the Ack cycle.
package dmem_pkg;
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  typedef struct packed {
    logic       ack;
    logic       err;
    logic       ld;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } resp_t;
endpackage

// File: rtl/dmem_lane.sv
// Combinational byte-lane logic: store byte enables / replicated data, and
// load extraction with sign or zero extension.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]       st_size,
  input  logic [1:0]       st_lane,
  input  logic [31:0]      wdata,
  output logic [LANES-1:0] be,
  output logic [31:0]      wrep,
  input  logic [1:0]       ld_size,
  input  logic [1:0]       ld_lane,
  input  logic             uns,
  input  logic [31:0]      rword,
  output logic [31:0]      rdat
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    be   = '0;
    wrep = wdata;
    case (st_size)
      SZ_BYTE: begin
        be   = LANES'(1) << st_lane;
        wrep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be   = st_lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      SZ_WORD: be = '1;
      default: be = '0;
    endcase
  end

  always_comb begin
    b    = 8'(rword >> {ld_lane, 3'b000});
    h    = ld_lane[1] ? rword[31:16] : rword[15:0];
    rdat = '0;
    case (ld_size)
      SZ_BYTE: rdat = {{24{~uns & b[7]}}, b};
      SZ_HALF: rdat = {{16{~uns & h[15]}}, h};
      SZ_WORD: rdat = rword;
      default: rdat = '0;
    endcase
  end
endmodule

// File: rtl/dmem_ls.sv
// Clocked data memory with load/store lane unit: zeroing sweep after reset,
// stores written on the accepting edge, loads read from registered address.
module dmem_ls
  import dmem_pkg::*;
#(
  parameter int AWIDTH    = 32,
  parameter int ALENGTH   = 128,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              Rdy,
  input  logic              Req,
  input  logic              WE2,
  input  logic [1:0]        Size,
  input  logic              Uns,
  input  logic [AWIDTH-1:0] Addr,
  input  logic [31:0]       WriDat,
  output logic [31:0]       ReaDat,
  output logic              Ack,
  output logic              Err
);
  localparam int IDX = $clog2(ALENGTH);

  state_t           state_q, state_d;
  logic [IDX-1:0]   cnt_q, cnt_d;
  logic [IDX-1:0]   idx_q, idx_d;
  resp_t            rsp_q, rsp_d;
  reg   [31:0]      mem [ALENGTH];

  logic             acc, oor, mis, bad;
  logic [IDX-1:0]   widx;
  logic [LANES-1:0] st_be, mem_be;
  logic [31:0]      st_wd, mem_wd, ld_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_ZERO != 0) ? INIT : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX'(ALENGTH - 1)) state_d = IDLE;
    end
  end

  always_comb begin
    Rdy = (state_q == IDLE);
  end

  always_comb begin
    oor = (Addr >> (IDX + 2)) != '0;
    mis = (Size == SZ_HALF && Addr[0]) || (Size == SZ_WORD && Addr[1:0] != 2'b00);
    bad = oor | mis | (Size == 2'b11);
    acc = Rdy & Req;
  end

  always_comb begin
    rsp_d.ack  = acc;
    rsp_d.err  = acc & bad;
    rsp_d.ld   = acc & ~WE2;
    rsp_d.size = Size;
    rsp_d.uns  = Uns;
    rsp_d.lane = Addr[1:0];
    idx_d      = Addr[IDX+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q <= '0;
      idx_q <= '0;
    end else begin
      rsp_q <= rsp_d;
      idx_q <= idx_d;
    end
  end

  // The sweep owns the write port while in INIT; requests are not accepted then.
  always_comb begin
    widx   = Addr[IDX+1:2];
    mem_be = '0;
    mem_wd = st_wd;
    if (state_q == INIT) begin
      widx   = cnt_q;
      mem_be = '1;
      mem_wd = '0;
    end else if (acc && WE2 && !bad) begin
      mem_be = st_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < LANES; k++)
        if (mem_be[k]) mem[widx][8*k +: 8] <= mem_wd[8*k +: 8];
    end
  end

  dmem_lane u_lane (
    .st_size (Size),
    .st_lane (Addr[1:0]),
    .wdata   (WriDat),
    .be      (st_be),
    .wrep    (st_wd),
    .ld_size (rsp_q.size),
    .ld_lane (rsp_q.lane),
    .uns     (rsp_q.uns),
    .rword   (mem[idx_q]),
    .rdat    (ld_dat)
  );

  always_comb begin
    Ack    = rsp_q.ack;
    Err    = rsp_q.err;
    ReaDat = (rsp_q.ack && rsp_q.ld && !rsp_q.err) ? ld_dat : '0;
  end
endmodule

// File: tb/tb_dmem_ls.sv
// Directed bench for dmem_ls: init sweep timing, lane/extension cases,
// error responses, reset interaction and back-to-back traffic.
module tb_dmem_ls;
  logic        clk, rst, Rdy, Req, WE2, Uns, Ack, Err;
  logic [1:0]  Size;
  logic [31:0] Addr, WriDat, ReaDat;
  logic [31:0] rd_s;
  logic        ak_s, er_s;
  int          n_chk = 0, n_pass = 0;
  int          cyc;

  dmem_ls dut (
    .clk(clk), .rst(rst), .Rdy(Rdy), .Req(Req), .WE2(WE2), .Size(Size),
    .Uns(Uns), .Addr(Addr), .WriDat(WriDat), .ReaDat(ReaDat), .Ack(Ack), .Err(Err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Called 1ns after a rising edge; samples the response 1ns after the accepting edge.
  task automatic req(input logic we, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    Req = 1; WE2 = we; Size = sz; Uns = u; Addr = a; WriDat = d;
    @(posedge clk); #1;
    Req = 0;
    rd_s = ReaDat; ak_s = Ack; er_s = Err;
  endtask

  task automatic acc(input string tag, input logic we, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e);
    req(we, sz, u, a, d);
    chk({tag, ".ack"}, 32'(ak_s), 32'd1);
    chk({tag, ".err"}, 32'(er_s), 32'(exp_e));
    chk({tag, ".dat"}, rd_s, exp_d);
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!Rdy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    rst = 1; Req = 0; WE2 = 0; Size = 2'b10; Uns = 0; Addr = '0; WriDat = '0;
    @(posedge clk); #1;
    chk("rst.rdy", 32'(Rdy), 32'd0);
    chk("rst.ack", 32'(Ack), 32'd0);
    chk("rst.err", 32'(Err), 32'd0);
    chk("rst.dat", ReaDat, 32'd0);
    rst = 0;
    wait_rdy(cyc);
    chk("init.cycles", 32'(cyc), 32'd128);

    acc("ld1fc", 0, 2'b10, 0, 32'h1FC, 0, 32'h0, 0);
    acc("st7c",  1, 2'b10, 0, 32'h7C, 32'h6000, 32'h0, 0);
    acc("ld7c",  0, 2'b10, 0, 32'h7C, 0, 32'h6000, 0);

    acc("st10",   1, 2'b10, 0, 32'h10, 32'h12345678, 32'h0, 0);
    acc("lb13",   0, 2'b00, 0, 32'h13, 0, 32'h12, 0);
    acc("lh10",   0, 2'b01, 0, 32'h10, 0, 32'h5678, 0);
    acc("sb11",   1, 2'b00, 0, 32'h11, 32'h80, 32'h0, 0);
    acc("lb11s",  0, 2'b00, 0, 32'h11, 0, 32'hFFFFFF80, 0);
    acc("lb11u",  0, 2'b00, 1, 32'h11, 0, 32'h00000080, 0);
    acc("lw10",   0, 2'b10, 0, 32'h10, 0, 32'h12348078, 0);
    acc("sh16",   1, 2'b01, 0, 32'h16, 32'h5555BEEF, 32'h0, 0);
    acc("lw14",   0, 2'b10, 0, 32'h14, 0, 32'hBEEF0000, 0);
    acc("lh16s",  0, 2'b01, 0, 32'h16, 0, 32'hFFFFBEEF, 0);
    acc("lh16u",  0, 2'b01, 1, 32'h16, 0, 32'h0000BEEF, 0);

    acc("sw7f",   1, 2'b10, 0, 32'h7F, 32'hDEADBEEF, 32'h0, 1);
    acc("lh81",   0, 2'b01, 0, 32'h81, 0, 32'h0, 1);
    acc("lw200",  0, 2'b10, 0, 32'h200, 0, 32'h0, 1);
    acc("lw210",  0, 2'b10, 0, 32'h210, 0, 32'h0, 1);
    acc("sz11",   0, 2'b11, 0, 32'h7C, 0, 32'h0, 1);
    acc("sb7c_bad", 1, 2'b11, 0, 32'h7C, 32'hFF, 32'h0, 1);
    acc("ld7c_2", 0, 2'b10, 0, 32'h7C, 0, 32'h6000, 0);
    @(posedge clk); #1;
    chk("idle.ack", 32'(Ack), 32'd0);

    // Load/store/load to one word keeps program order.
    acc("ord.st0", 1, 2'b10, 0, 32'h40, 32'h11111111, 32'h0, 0);
    acc("ord.ld0", 0, 2'b10, 0, 32'h40, 0, 32'h11111111, 0);
    acc("ord.st1", 1, 2'b10, 0, 32'h40, 32'h22222222, 32'h0, 0);
    acc("ord.ld1", 0, 2'b10, 0, 32'h40, 0, 32'h22222222, 0);

    // Reset mid-sweep restarts the full sweep.
    rst = 1; @(posedge clk); #1; rst = 0;
    repeat (60) @(posedge clk);
    #1;
    chk("sweep60.rdy", 32'(Rdy), 32'd0);
    rst = 1; @(posedge clk); #1; rst = 0;
    wait_rdy(cyc);
    chk("resweep.cycles", 32'(cyc), 32'd128);
    acc("cleared7c", 0, 2'b10, 0, 32'h7C, 0, 32'h0, 0);

    // Reset coincident with an accepted store.
    Req = 1; WE2 = 1; Size = 2'b10; Addr = 32'h0; WriDat = 32'hA5A5A5A5; rst = 1;
    @(posedge clk); #1;
    chk("rstreq.ack", 32'(Ack), 32'd0);
    chk("rstreq.rdy", 32'(Rdy), 32'd0);
    Req = 0; rst = 0;
    @(posedge clk); #1;
    chk("rstreq.ack2", 32'(Ack), 32'd0);
    wait_rdy(cyc);
    chk("rstreq.cycles", 32'(cyc), 32'd127);
    acc("rstreq.ld0", 0, 2'b10, 0, 32'h0, 0, 32'h0, 0);

    // Back-to-back alternating store/load over 8 words, Req held high.
    for (int j = 0; j < 16; j++) begin
      int i;
      logic [31:0] dv;
      i = j / 2;
      dv = 32'hC0DE0000 | (32'(i) * 32'h111);
      Req = 1; WE2 = (j % 2 == 0); Size = 2'b10; Uns = 0;
      Addr = 32'h100 + 32'(i) * 4; WriDat = dv;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.ack", j), 32'(Ack), 32'd1);
      chk($sformatf("b2b%0d.err", j), 32'(Err), 32'd0);
      chk($sformatf("b2b%0d.dat", j), ReaDat, (j % 2 == 0) ? 32'h0 : dv);
    end
    Req = 0;
    @(posedge clk); #1;
    chk("b2b.end.ack", 32'(Ack), 32'd0);
    acc("b2b.recheck", 0, 2'b10, 0, 32'h104, 0, 32'hC0DE0111, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
